// File: rtl/tlk2711_pkg.sv
// rtl/tlk2711_pkg.sv - shared types and width helpers for the DMA read arbiter
package tlk2711_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    function automatic int cmd_w(input int dlen_width, input int addr_width);
        return dlen_width + addr_width;
    endfunction

    function automatic int id_w(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/tlk2711_rr_pick.sv
// rtl/tlk2711_rr_pick.sv - combinational round-robin winner search starting after ptr
module tlk2711_rr_pick
    import tlk2711_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    id,
    output logic               valid
);

    localparam logic [ID_W:0] NUM_W  = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W:0] LAST_W = (ID_W+1)'(NUM_REQ - 1);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [ID_W:0]        start;
    logic [ID_W:0]        offset;
    logic [ID_W:0]        sum;

    // Rotate so the slot after ptr lands at bit 0, find first set, rotate back.
    always_comb begin
        req_dbl = {req, req};
        start   = ({1'b0, ptr} == LAST_W) ? '0 : ({1'b0, ptr} + (ID_W+1)'(1));
        req_rot = req_dbl[start +: NUM_REQ];
        valid   = |req;
        offset  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = (ID_W+1)'(i);
            end
        end
        sum = start + offset;
        if (sum >= NUM_W) begin
            sum = sum - NUM_W;
        end
        id = sum[ID_W-1:0];
    end

endmodule

// File: rtl/tlk2711_dma_rd_arb.sv
// rtl/tlk2711_dma_rd_arb.sv - round-robin arbiter for the shared DMA read command channel
module tlk2711_dma_rd_arb
    import tlk2711_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int ADDR_WIDTH = 48,
    parameter  int DLEN_WIDTH = 16,
    parameter  int TO_WIDTH   = 24,
    localparam int CMD_W      = cmd_w(DLEN_WIDTH, ADDR_WIDTH),
    localparam int ID_W       = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_soft_rst,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*CMD_W-1:0] i_cmd_data,
    output logic [NUM_REQ-1:0]       o_ack,
    output logic [NUM_REQ-1:0]       o_done,
    output logic                     o_rd_cmd_req,
    output logic [CMD_W-1:0]         o_rd_cmd_data,
    input  logic                     i_rd_cmd_ack,
    input  logic                     i_dma_rd_valid,
    input  logic                     i_dma_rd_ready,
    input  logic                     i_dma_rd_last,
    output logic [ID_W-1:0]          o_grant_id,
    output logic                     o_busy,
    input  logic [TO_WIDTH-1:0]      i_timeout_limit,
    output logic                     o_timeout,
    output logic                     o_timeout_sticky
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    arb_state_e           state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [CMD_W-1:0]     cmd_q, cmd_d;
    logic [TO_WIDTH-1:0]  cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 req_q, req_d;
    logic                 busy_q, busy_d;
    logic                 to_q, to_d;
    logic                 sticky_q, sticky_d;
    logic [ID_W-1:0]      pick_id;
    logic                 pick_valid;
    logic                 wd_hit;
    logic                 done_evt;

    tlk2711_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req   (i_req),
        .ptr   (ptr_q),
        .id    (pick_id),
        .valid (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        done_d   = '0;
        to_d     = 1'b0;
        sticky_d = sticky_q;
        wd_hit   = (i_timeout_limit != '0) && (cnt_q == i_timeout_limit);
        done_evt = i_dma_rd_valid & i_dma_rd_ready & i_dma_rd_last;

        if (i_soft_rst) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ptr_d   = LAST_ID;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        id_d = pick_id;
                        for (int k = 0; k < NUM_REQ; k++) begin
                            if (pick_id == ID_W'(k)) begin
                                cmd_d = i_cmd_data[k*CMD_W +: CMD_W];
                            end
                        end
                        cnt_d   = '0;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_d = cnt_q + TO_WIDTH'(1);
                    // Ack outranks a watchdog expiry in the same cycle.
                    if (i_rd_cmd_ack) begin
                        ack_d[id_q] = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_WAIT;
                    end else if (wd_hit) begin
                        to_d     = 1'b1;
                        sticky_d = 1'b1;
                        ptr_d    = id_q;
                        state_d  = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt_d = cnt_q + TO_WIDTH'(1);
                    if (done_evt) begin
                        done_d[id_q] = 1'b1;
                        ptr_d        = id_q;
                        state_d      = ST_IDLE;
                    end else if (wd_hit) begin
                        to_d     = 1'b1;
                        sticky_d = 1'b1;
                        ptr_d    = id_q;
                        state_d  = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        req_d  = (state_d == ST_ISSUE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= LAST_ID;
            id_q     <= '0;
            cmd_q    <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            done_q   <= '0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            to_q     <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            to_q     <= to_d;
            sticky_q <= sticky_d;
        end
    end

    assign o_ack            = ack_q;
    assign o_done           = done_q;
    assign o_rd_cmd_req     = req_q;
    assign o_rd_cmd_data    = cmd_q;
    assign o_grant_id       = id_q;
    assign o_busy           = busy_q;
    assign o_timeout        = to_q;
    assign o_timeout_sticky = sticky_q;

endmodule

// File: tb/tb_tlk2711_dma_rd_arb.sv
// tb/tb_tlk2711_dma_rd_arb.sv - self-checking bench for tlk2711_dma_rd_arb
module tb_tlk2711_dma_rd_arb;

    localparam int N  = 4;
    localparam int AW = 48;
    localparam int DW = 16;
    localparam int TW = 24;
    localparam int CW = AW + DW;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_soft_rst = 1'b0;
    logic [N-1:0]    i_req = '0;
    logic [N*CW-1:0] i_cmd_data;
    logic [N-1:0]    o_ack, o_done;
    logic            o_rd_cmd_req;
    logic [CW-1:0]   o_rd_cmd_data;
    logic            i_rd_cmd_ack = 1'b0;
    logic            dv = 1'b0, dr = 1'b0, dl = 1'b0;
    logic [IW-1:0]   o_grant_id;
    logic            o_busy;
    logic [TW-1:0]   lim = '0;
    logic            o_timeout, o_timeout_sticky;

    logic [CW-1:0]   cmd [N];
    int              checks = 0;
    int              failures = 0;

    typedef struct packed {
        logic [N-1:0] req;
        logic         ack;
        logic         v;
        logic         r;
        logic         l;
        logic [N-1:0] e_ack;
        logic [N-1:0] e_done;
        logic         e_req;
        logic         e_busy;
    } vec_t;
    vec_t tbl [9];

    int              m_phase, m_id, m_last;
    longint          m_deadline;
    logic            m_sticky;
    logic [CW-1:0]   m_cmd;
    logic [N-1:0]    e_ack, e_done;
    logic            e_to;
    int              n, w;
    logic            saw_done;
    int              prev_gnt;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            i_cmd_data[k*CW +: CW] = cmd[k];
        end
    end

    tlk2711_dma_rd_arb #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DLEN_WIDTH(DW), .TO_WIDTH(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_soft_rst(i_soft_rst), .i_req(i_req),
        .i_cmd_data(i_cmd_data), .o_ack(o_ack), .o_done(o_done),
        .o_rd_cmd_req(o_rd_cmd_req), .o_rd_cmd_data(o_rd_cmd_data),
        .i_rd_cmd_ack(i_rd_cmd_ack), .i_dma_rd_valid(dv), .i_dma_rd_ready(dr),
        .i_dma_rd_last(dl), .o_grant_id(o_grant_id), .o_busy(o_busy),
        .i_timeout_limit(lim), .o_timeout(o_timeout), .o_timeout_sticky(o_timeout_sticky)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        i_req = '0; i_rd_cmd_ack = 1'b0; dv = 1'b0; dr = 1'b0; dl = 1'b0; i_soft_rst = 1'b0;
    endtask

    function automatic logic [127:0] all_outs();
        return {o_ack, o_done, o_rd_cmd_req, o_rd_cmd_data, o_grant_id, o_busy, o_timeout, o_timeout_sticky};
    endfunction

    // Transaction-level reference: grant = first pending after last served;
    // watchdog expressed as an absolute deadline cycle, L+2 after the starting event.
    task automatic model_step(input longint t);
        logic found;
        logic fire;
        int   cnd;
        e_ack = '0; e_done = '0; e_to = 1'b0;
        if (i_soft_rst) begin
            m_phase = 0;
            m_last  = N - 1;
        end else if (m_phase == 0) begin
            if (i_req != '0) begin
                found = 1'b0;
                for (int i = 1; i <= N; i++) begin
                    cnd = (m_last + i) % N;
                    if (!found && i_req[cnd]) begin
                        m_id  = cnd;
                        found = 1'b1;
                    end
                end
                m_cmd      = cmd[m_id];
                m_phase    = 1;
                m_deadline = t + longint'(lim) + 2;
            end
        end else begin
            fire = (lim != '0) && (t + 1 == m_deadline);
            if (m_phase == 1 && i_rd_cmd_ack) begin
                e_ack[m_id] = 1'b1;
                m_phase     = 2;
                m_deadline  = t + longint'(lim) + 2;
            end else if (m_phase == 2 && dv && dr && dl) begin
                e_done[m_id] = 1'b1;
                m_last       = m_id;
                m_phase      = 0;
            end else if (fire) begin
                e_to     = 1'b1;
                m_sticky = 1'b1;
                m_last   = m_id;
                m_phase  = 0;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=stuck expected=finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            cmd[k] = {DW'(256 + k), AW'(64'h1234_0000 + k * 4096)};
        end
        tbl[0] = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1};
        tbl[1] = '{4'b0001, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1};
        tbl[2] = '{4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1};
        tbl[3] = '{4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
        tbl[4] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1};
        tbl[5] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
        tbl[6] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1};
        tbl[7] = '{4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0};
        tbl[8] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};

        step(); step();
        check("reset_outputs", all_outs(), '0);
        rst_n = 1'b1;

        // Single request, watchdog disabled
        for (int i = 0; i < 9; i++) begin
            i_req = tbl[i].req; i_rd_cmd_ack = tbl[i].ack;
            dv = tbl[i].v; dr = tbl[i].r; dl = tbl[i].l;
            step();
            check($sformatf("tbl_row%0d", i), {o_rd_cmd_req, o_busy, o_ack, o_done},
                  {tbl[i].e_req, tbl[i].e_busy, tbl[i].e_ack, tbl[i].e_done});
            if (i == 0) begin
                check("tbl_cmd_data", o_rd_cmd_data, cmd[0]);
                check("tbl_grant", o_grant_id, 0);
            end
        end
        clear_in();

        // Fairness with all requesters held
        i_soft_rst = 1'b1; step(); i_soft_rst = 1'b0;
        i_req = 4'b1111;
        prev_gnt = -1;
        for (int t = 0; t < 5; t++) begin
            w = 0;
            while (!o_rd_cmd_req && w < 20) begin step(); w++; end
            check("fair_issue", o_rd_cmd_req, 1);
            check($sformatf("fair_grant%0d", t), o_grant_id, t % N);
            check("fair_no_repeat", (int'(o_grant_id) != prev_gnt), 1);
            prev_gnt = int'(o_grant_id);
            i_rd_cmd_ack = 1'b1; step(); i_rd_cmd_ack = 1'b0;
            check("fair_ack", o_ack, 4'b0001 << (t % N));
            step();
            dv = 1'b1; dr = 1'b1; dl = 1'b1; step(); dv = 1'b0; dr = 1'b0; dl = 1'b0;
            check("fair_done", o_done, 4'b0001 << (t % N));
        end
        clear_in();

        // Watchdog expiry in WAIT
        lim = 16;
        i_soft_rst = 1'b1; step(); i_soft_rst = 1'b0;
        i_req = 4'b0011; step();
        check("to_grant0", {o_rd_cmd_req, o_grant_id}, {1'b1, 2'd0});
        i_rd_cmd_ack = 1'b1; step(); i_rd_cmd_ack = 1'b0; i_req = 4'b0010;
        check("to_ack", o_ack, 4'b0001);
        n = 0; saw_done = 1'b0;
        while (!o_timeout && n < 40) begin
            step(); n++;
            if (o_done != '0) saw_done = 1'b1;
        end
        check("to_latency", n, 17);
        check("to_sticky_idle", {o_timeout_sticky, o_busy, saw_done}, 3'b100);
        step();
        check("to_next_grant", {o_rd_cmd_req, o_grant_id, o_timeout}, {1'b1, 2'd1, 1'b0});
        i_req = '0; i_rd_cmd_ack = 1'b1; step(); i_rd_cmd_ack = 1'b0;
        dv = 1'b1; dr = 1'b1; dl = 1'b1; step(); clear_in();

        // Ack on the limit cycle, then last beat on the limit cycle
        lim = 4;
        i_soft_rst = 1'b1; step(); i_soft_rst = 1'b0;
        i_req = 4'b0001; step(); i_req = '0;
        check("aol_issue", o_rd_cmd_req, 1);
        repeat (4) step();
        check("aol_pre_no_to", {o_timeout, o_rd_cmd_req}, 2'b01);
        i_rd_cmd_ack = 1'b1; step(); i_rd_cmd_ack = 1'b0;
        check("aol_ack_wins", {o_ack, o_timeout, o_busy}, {4'b0001, 1'b0, 1'b1});
        repeat (4) step();
        dv = 1'b1; dr = 1'b1; dl = 1'b1; step(); clear_in();
        check("dol_done_wins", {o_done, o_timeout, o_busy}, {4'b0001, 1'b0, 1'b0});

        // Soft reset while waiting for data
        i_req = 4'b0100; step(); i_req = '0;
        check("srst_grant2", o_grant_id, 2);
        i_rd_cmd_ack = 1'b1; step(); i_rd_cmd_ack = 1'b0;
        check("srst_ack", o_ack, 4'b0100);
        i_soft_rst = 1'b1; dv = 1'b1; dr = 1'b1; dl = 1'b1; step(); clear_in();
        check("srst_quiet", {o_busy, o_done, o_ack, o_rd_cmd_req, o_timeout}, '0);
        check("srst_sticky_kept", o_timeout_sticky, 1);
        i_req = 4'b1111; step();
        check("srst_req0_wins", {o_rd_cmd_req, o_grant_id}, {1'b1, 2'd0});

        // Async reset during ISSUE, no clock edge
        #3 rst_n = 1'b0;
        #1 check("areset_outputs", all_outs(), '0);
        i_req = '0; step(); step();
        rst_n = 1'b1;
        i_req = 4'b1111; step();
        check("areset_resume", {o_rd_cmd_req, o_busy, o_grant_id}, {1'b1, 1'b1, 2'd0});

        // Randomized run against the reference model
        clear_in();
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        m_phase = 0; m_id = 0; m_last = N - 1; m_sticky = 1'b0; m_cmd = '0; m_deadline = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) i_req = N'($urandom);
            i_rd_cmd_ack = ($urandom_range(0, 4) == 0);
            dv = 1'($urandom); dr = 1'($urandom); dl = ($urandom_range(0, 2) == 0);
            i_soft_rst = ($urandom_range(0, 199) == 0);
            cmd[$urandom_range(0, N - 1)] = {$urandom, $urandom};
            if (c % 400 == 0) begin
                i_soft_rst = 1'b1;
                case ($urandom_range(0, 4))
                    0: lim = 0;
                    1: lim = 1;
                    2: lim = 2;
                    3: lim = 5;
                    default: lim = 12;
                endcase
            end
            model_step(longint'(c));
            step();
            check($sformatf("rand_c%0d", c),
                  {o_rd_cmd_req, o_busy, o_grant_id, o_rd_cmd_data, o_ack, o_done, o_timeout, o_timeout_sticky},
                  {(m_phase == 1), (m_phase != 0), IW'(m_id), m_cmd, e_ack, e_done, e_to, m_sticky});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlk2711_dma_rd_arb.md
# tlk2711_dma_rd_arb

Round-robin scheduler that shares the single DMA read-command channel (command req/ack plus the read data stream's last beat) between up to NUM_REQ command sources, for example the TX command generator and a future test-pattern or register-readback reader. The block sits between the requesters and the DMA engine's read command port. It grants one requester at a time and holds the grant until that transfer's last data beat has been consumed. A per-transfer watchdog prevents a stalled transfer from locking out the other requesters.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_WIDTH, 48: DMA address width.
- DLEN_WIDTH, 16: DMA length width. CMD_W = DLEN_WIDTH+ADDR_WIDTH.
- TO_WIDTH, 24: watchdog counter width.

Ports:
- clk  in  1  single clock; all logic runs on it.
- rst_n  in  1  reset, asynchronous and active-low.
- i_soft_rst  in  1  synchronous abort to IDLE.
- i_req  in  NUM_REQ  per-requester command request; level, held until o_ack.
- i_cmd_data  in  NUM_REQ*CMD_W  requester k occupies bits [k*CMD_W +: CMD_W].
- o_ack  out  NUM_REQ  one-cycle pulse to the granted requester when its command is accepted downstream.
- o_done  out  NUM_REQ  one-cycle pulse when the granted transfer's last beat completes.
- o_rd_cmd_req  out  1  command request to the DMA.
- o_rd_cmd_data  out  CMD_W  latched command.
- i_rd_cmd_ack  in  1  DMA command accept, single-cycle pulse.
- i_dma_rd_valid, i_dma_rd_ready, i_dma_rd_last  in  1 each  DMA read stream, monitored only.
- o_grant_id  out  $clog2(NUM_REQ)  current or last grant.
- o_busy  out  1  high when the state is not IDLE.
- i_timeout_limit  in  TO_WIDTH  watchdog limit in cycles; 0 disables the watchdog.
- o_timeout  out  1  one-cycle pulse when the watchdog expires.
- o_timeout_sticky  out  1  set on watchdog expiry; cleared only by a reset.

## Operation
- State IDLE:
  - Samples i_req.
  - If any bit is set, picks the first set bit searching upward from ptr+1 modulo NUM_REQ.
  - Latches that requester's command and its id.
  - Moves to ISSUE.
- State ISSUE:
  - o_rd_cmd_req is 1 and o_rd_cmd_data holds the latched command, stable.
  - On i_rd_cmd_ack: o_ack[id] pulses, the watchdog counter clears, and the state moves to WAIT.
- State WAIT:
  - The completion event is i_dma_rd_valid & i_dma_rd_ready & i_dma_rd_last.
  - On that event: o_done[id] pulses, ptr becomes id, and the state moves to IDLE.
- Watchdog:
  - The counter increments every cycle in ISSUE and WAIT and clears on entering ISSUE and on ack.
  - When the limit is nonzero and the counter equals the limit: o_timeout pulses, the sticky flag sets, ptr becomes id, the state moves to IDLE, and no o_ack or o_done is issued.
- Simultaneous events:
  - Ack and timeout in the same cycle: the ack wins.
  - Completion and timeout in the same cycle: the completion wins.
- Stream beats seen in IDLE or ISSUE are ignored.
- i_req changes outside IDLE are ignored. A requester that drops i_req during ISSUE is still served.
- i_soft_rst: the state goes to IDLE, o_rd_cmd_req goes to 0, the counter clears, and ptr goes to NUM_REQ-1. No pulses are issued.

## Timing
- Reset values: all outputs 0, ptr = NUM_REQ-1 so that requester 0 wins first, state IDLE.
- Request to command: if i_req is seen in IDLE at cycle n, o_rd_cmd_req is 1 from cycle n+1. o_grant_id is valid from n+1.
- Ack: if ack arrives at cycle m, o_ack pulses and the state is WAIT at m+1. o_rd_cmd_req is 0 from m+1.
- Done: if the last beat arrives at cycle k, o_done pulses and the state is IDLE at k+1. The next o_rd_cmd_req is asserted no earlier than k+2.
- Back-to-back: the minimum spacing between two commands is 3 cycles (plus the data phase).
- Timeout: with limit L, o_timeout pulses L+1 cycles after entering ISSUE or after the ack.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- tlk2711_pkg holds:
  - the CMD_W helper,
  - the state encoding (IDLE=0, ISSUE=1, WAIT=2),
  - a function for the id width.
- Sub-module tlk2711_rr_pick: purely combinational rotate, find-first-set and rotate-back. Inputs are req and ptr; outputs are the winner id and a valid flag.
- Top of the block: FSM, command latch, watchdog, pointer.

## Test plan
- Single request, NUM_REQ=4: i_req=4'b0001, ack after 2 cycles, last beat after 5 more.
  - o_rd_cmd_req rises one cycle after the request.
  - o_ack=0001 one cycle after the ack.
  - o_done=0001 one cycle after the last beat.
  - o_rd_cmd_data equals requester 0's field.
- Fairness: i_req=4'b1111 held, each transfer completing.
  - Grant order is 0,1,2,3,0.
  - No requester is granted twice in a row while others are pending.
- Timeout: i_timeout_limit=16, ack given, last beat never arrives.
  - o_timeout pulses 17 cycles after the ack and the sticky flag sets.
  - The next pending requester is granted.
  - No o_done is issued.
- Simultaneous events:
  - Ack in the same cycle the counter hits the limit: o_ack is issued and there is no timeout.
  - Last beat on the limit cycle: o_done is issued and there is no timeout.
- Soft reset mid-WAIT:
  - o_busy goes to 0 the next cycle, with no o_done or o_ack.
  - Requester 0 wins the next arbitration.
- Async reset asserted mid-ISSUE: all outputs are 0 immediately, with no clock edge required. After release, operation resumes from IDLE.
